// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous-read word memory.
// Define MEM_ARB_RR_EN for round-robin IDLE arbitration (default: fixed priority, requester 0 first).
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] addr_q;
    logic              prefer1;
    logic              any_gnt, win_lock, forced;

`ifdef MEM_ARB_RR_EN
    logic              last_win_q;
    assign prefer1 = ~last_win_q;
`else
    // Set only after a forced release of requester 0, so the waiting side gets the next slot.
    logic              pri1_q;
    assign prefer1 = pri1_q;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state_q)
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: begin
                    gnt0 = req0 & ~(req1 & prefer1);
                    gnt1 = req1 & ~(req0 & ~prefer1);
                end
            endcase
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign win_lock  = gnt1 ? lock1 : lock0;
    assign mem_we    = (gnt1 & we1) | (gnt0 & we0);
    assign mem_wdata = gnt1 ? wdata1 : (gnt0 ? wdata0 : '0);
    // Holding the last granted address keeps the memory's read address register stable.
    assign mem_addr  = gnt1 ? addr1 : (gnt0 ? addr0 : addr_q);
    assign rd_pend_d = {gnt1 & ~we1, gnt0 & ~we0};
    assign cnt_inc   = cnt_q + 1'b1;
    assign forced    = (LOCK_MAX != 0) && any_gnt && win_lock && (cnt_inc == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (any_gnt) begin
            if (win_lock && !forced) begin
                state_d = gnt1 ? OWN1 : OWN0;
                if (LOCK_MAX != 0) cnt_d = cnt_inc;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    assign rvalid0 = rd_pend_q[0];
    assign rvalid1 = rd_pend_q[1];
    assign rdata0  = rd_pend_q[0] ? mem_rdata : '0;
    assign rdata1  = rd_pend_q[1] ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_pend_q  <= '0;
            addr_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_win_q <= 1'b1;
`else
            pri1_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            if (any_gnt) begin
                addr_q     <= mem_addr;
`ifdef MEM_ARB_RR_EN
                last_win_q <= gnt1;
`else
                pri1_q     <= forced & gnt0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a behavioural synchronous-read memory.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int TB_LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(TB_LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: writes at the edge, read address registered only on non-write cycles.
    logic [DW-1:0] ram [4096];
    logic [AW-1:0] ram_raddr_q = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        ram_raddr_q   <= mem_addr;
    end
    assign mem_rdata = ram[ram_raddr_q];

    typedef struct packed {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } stim_t;

    typedef struct {
        logic          g0, g1, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rv0, rv1;
        logic [DW-1:0] rd0, rd1;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [4096];
    int            m_owner = -1;
    int            m_cnt = 0;
    int            m_prefer = 0;
    int            m_last_w = -1;
    logic [AW-1:0] m_last_addr = '0;
    logic          m_rv [2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_rd [2] = '{'0, '0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic w, input logic l,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        stim_t s;
        s.req = r; s.we = w; s.lock = l; s.addr = a; s.wdata = d;
        return s;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_cnt = 0;
        m_prefer = 0;
        m_last_w = -1;
        m_last_addr = '0;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
    endfunction

    // Applies one cycle of stimulus, optionally with a reset pulse early in the cycle.
    task automatic cyc(input bit do_rst, input stim_t s0, input stim_t s1);
        stim_t s [2];
        exp_t  e;
        int    w;
        bit    frc;
        s[0] = s0;
        s[1] = s1;
        @(posedge clk);
        #1;
        if (do_rst) begin
            rst = 1'b1;
            req0 = 1'b1; we0 = 1'b0; addr0 = 12'h007; req1 = 1'b1; we1 = 1'b1; addr1 = 12'h009;
            #1;
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_rvalid0", rvalid0, 0);
            chk("rst_rvalid1", rvalid1, 0);
            chk("rst_rdata0", rdata0, 0);
            chk("rst_rdata1", rdata1, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            #1;
            rst = 1'b0;
            model_reset();
        end
        req0 = s0.req; we0 = s0.we; lock0 = s0.lock; addr0 = s0.addr; wdata0 = s0.wdata;
        req1 = s1.req; we1 = s1.we; lock1 = s1.lock; addr1 = s1.addr; wdata1 = s1.wdata;

        e.rv0 = m_rv[0]; e.rd0 = m_rv[0] ? m_rd[0] : '0;
        e.rv1 = m_rv[1]; e.rd1 = m_rv[1] ? m_rd[1] : '0;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;

        w = -1;
        if (m_owner >= 0) begin
            if (s[m_owner].req) w = m_owner;
        end else if (s[0].req && s[1].req) w = m_prefer;
        else if (s[0].req) w = 0;
        else if (s[1].req) w = 1;
        m_last_w = w;

        e.g0 = (w == 0);
        e.g1 = (w == 1);
        e.wdata = '0;
        if (w >= 0) begin
            e.addr = s[w].addr;
            e.we = s[w].we;
            e.wdata = s[w].wdata;
            m_last_addr = s[w].addr;
            if (s[w].we) ref_mem[s[w].addr] = s[w].wdata;
            else begin
                m_rv[w] = 1'b1;
                m_rd[w] = ref_mem[s[w].addr];
            end
            frc = 1'b0;
            if (s[w].lock) begin
                m_owner = w;
                m_cnt++;
                if (TB_LOCK_MAX != 0 && m_cnt >= TB_LOCK_MAX) begin
                    m_owner = -1;
                    m_cnt = 0;
                    frc = 1'b1;
                end
            end else begin
                m_owner = -1;
                m_cnt = 0;
            end
`ifdef MEM_ARB_RR_EN
            m_prefer = 1 - w;
`else
            m_prefer = frc ? 1 - w : 0;
`endif
        end else begin
            e.addr = m_last_addr;
            e.we = 1'b0;
        end
        expq.push_back(e);
    endtask

    // Monitor: compares the DUT against the oldest expected record once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("gnt0", gnt0, e.g0);
            chk("gnt1", gnt1, e.g1);
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            chk("rvalid0", rvalid0, e.rv0);
            chk("rvalid1", rvalid1, e.rv1);
            chk("rdata0", rdata0, e.rd0);
            chk("rdata1", rdata1, e.rd1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    stim_t idle;
    stim_t rs [2];

    initial begin
        idle = mk(0, 0, 0, 0, 0);
        cyc(1, idle, idle);

        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) cyc(0, mk(1, 1, 0, AW'(i), DW'($urandom)), idle);
            else            cyc(0, idle, mk(1, 1, 0, AW'(i), DW'($urandom)));
        end

        // Write then read on requester 1
        cyc(0, idle, mk(1, 1, 0, 12'h005, 12'hABC));
        cyc(0, idle, mk(1, 0, 0, 12'h005, 0));
        cyc(0, idle, idle);

        // Contention
        cyc(0, mk(1, 1, 0, 12'h010, 12'h111), idle);
        cyc(0, idle, mk(1, 1, 0, 12'h020, 12'h222));
        for (int i = 0; i < 6; i++)
            cyc(0, mk(1, 0, 0, 12'h010, 0), mk(1, 0, 0, 12'h020, 0));
        cyc(0, idle, idle);

        // Lock: three locked grants, then an unlocked one, with requester 1 waiting
        for (int i = 0; i < 3; i++)
            cyc(0, mk(1, 0, 1, AW'(i), 0), mk(1, 0, 0, 12'h020, 0));
        cyc(0, mk(1, 0, 0, 12'h003, 0), mk(1, 0, 0, 12'h020, 0));
        cyc(0, idle, mk(1, 0, 0, 12'h020, 0));
        cyc(0, idle, idle);

        // Forced release with lock held
        for (int i = 0; i < 7; i++)
            cyc(0, mk(1, 0, 1, 12'h010, 0), mk(1, 0, 0, 12'h020, 0));
        cyc(0, idle, idle);

        // Reset between the read grant and its data cycle
        cyc(0, mk(1, 1, 0, 12'h003, 12'h0F0), idle);
        cyc(0, mk(1, 0, 0, 12'h003, 0), idle);
        cyc(1, idle, idle);
        cyc(0, mk(1, 0, 0, 12'h003, 0), idle);

        // Read then write same address, then read back
        cyc(0, mk(1, 0, 0, 12'h003, 0), idle);
        cyc(0, mk(1, 1, 0, 12'h003, 12'h777), idle);
        cyc(0, mk(1, 0, 0, 12'h003, 0), idle);
        cyc(0, idle, idle);

        // Random traffic; a requester not yet granted keeps its request stable
        rs[0] = idle;
        rs[1] = idle;
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (!rs[x].req || m_last_w == x)
                    rs[x] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                               $urandom_range(0, 3) == 0, AW'($urandom_range(0, 63)), DW'($urandom));
            end
            cyc((n % 997) == 500, rs[0], rs[1]);
        end
        cyc(0, idle, idle);
        cyc(0, idle, idle);
        @(posedge clk);
        #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
